// File: rtl/hexdisplay_pkg.sv
// hexdisplay_pkg: shared constants, glyph table and counter-width helper for hex_scan_display.
package hexdisplay_pkg;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;
  // Active-low a..g patterns for 0..F, indexed by nibble value.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational nibble to active-low seven-segment glyph.
module hex_seg_decode
  import hexdisplay_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  assign glyph = GLYPH[nib];
endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed common-anode hex display scanner.
// Define HEXSCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_display
  import hexdisplay_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DIV     = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   load,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     an
);
  localparam int CW = cnt_width(DIV);
  localparam int IW = cnt_width(NDIGITS);
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [4*NDIGITS-1:0]   sh_val;
  logic [NDIGITS-1:0]     sh_dp;
  logic [NDIGITS-1:0]     blank;
  logic [3:0]             nib;
  logic                   dp_sel;
  logic                   blank_sel;
  logic [6:0]             glyph;
  logic [7:0]             seg_d;
  logic                   wrap;
  assign wrap = (cnt == CW'(DIV - 1));
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < NDIGITS; i++)
      if (idx == IW'(i)) begin
        nib       = sh_val[4*i +: 4];
        dp_sel    = sh_dp[i];
        blank_sel = blank[i];
      end
  end
`ifdef HEXSCAN_LZB_EN
  // A digit blanks only if it and every digit above it are zero; digit 0 always shows.
  logic lead;
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      lead     = lead & (sh_val[4*i +: 4] == 4'h0);
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif
  hex_seg_decode u_dec (
    .nib   (nib),
    .glyph (glyph)
  );
  always_comb begin
    seg_d             = {1'b1, blank_sel ? 7'h7F : glyph};
    seg_d[SEG_DP_BIT] = ~dp_sel;
  end
  // seg/an are built from the pre-edge idx, so they trail idx by one edge together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      sh_val <= '0;
      sh_dp  <= '0;
      seg    <= SEG_BLANK;
      an     <= '1;
    end else begin
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp;
      end
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
      seg <= seg_d;
      an  <= ~(NDIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: directed self-checking bench for hex_scan_display (4x4 and 1x2 instances).
`timescale 1ns/1ps
module tb_hex_scan_display;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [3:0]  value1;
  logic        dp1;
  logic        load1;
  logic [7:0]  seg1;
  logic        an1;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;

  hex_scan_display #(.NDIGITS(4), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .seg(seg), .an(an)
  );
  hex_scan_display #(.NDIGITS(1), .DIV(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value1), .dp(dp1), .load(load1), .seg(seg1), .an(an1)
  );

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] frame [4];
  logic [7:0] lz_hi;
  logic [3:0] ea;
  int         d;

  initial begin
    rst_n = 1'b0; value = '0; dp = '0; load = 1'b0;
    value1 = '0; dp1 = 1'b0; load1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_seg1", seg1, 8'hFF);
    chk("reset_an1", {7'h0, an1}, 8'h01);
    rst_n = 1'b1;
    // edges 1..16: one full frame of zeros, an E,D,B,7 each for 4 edges
    for (int k = 1; k <= 16; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(4'b0001 << d);
      chk($sformatf("scan_an_e%0d", k), {4'h0, an}, {4'h0, ea});
      chk($sformatf("scan_seg_e%0d", k), seg, 8'hC0);
    end
    // edge 17: capture 1A3F / dp on digit 2
    value = 16'h1A3F; dp = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load_stale_e17", seg, 8'hC0);
    frame = '{8'h8E, 8'hB0, 8'h08, 8'hF9};
    for (int k = 18; k <= 33; k++) begin
      tick();
      d  = ((k - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      chk($sformatf("frame_an_e%0d", k), {4'h0, an}, {4'h0, ea});
      chk($sformatf("frame_seg_e%0d", k), seg, frame[d]);
    end
    // edge 34: load FFFF, edge 36 (digit switch 0->1): load 0000
    value = 16'hFFFF; dp = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("ff_e34", seg, 8'h8E);
    tick();
    chk("ff_e35", seg, 8'h8E);
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("sw_seg_e36", seg, 8'h8E);
    chk("sw_an_e36", {4'h0, an}, 8'h0E);
    tick();
    chk("sw_seg_e37", seg, 8'hC0);
    chk("sw_an_e37", {4'h0, an}, 8'h0D);
    tick();
    chk("sw_seg_e38", seg, 8'hC0);
    // edges 39..42: now on digit 2
    repeat (4) tick();
    chk("pre_rst_an", {4'h0, an}, 8'h0B);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_an", {4'h0, an}, 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("restart_seg", seg, 8'hC0);
    chk("restart_an", {4'h0, an}, 8'h0E);
    repeat (4) tick();
    chk("restart_an_e5", {4'h0, an}, 8'h0D);
    // leading-zero blanking on 0050, fresh reset, load at edge 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    value = 16'h0050; dp = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("lzb_e1", seg, 8'hC0);
`ifdef HEXSCAN_LZB_EN
    lz_hi = 8'hFF;
`else
    lz_hi = 8'hC0;
`endif
    frame = '{8'hC0, 8'h92, lz_hi, lz_hi};
    for (int k = 2; k <= 17; k++) begin
      tick();
      d  = ((k - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      chk($sformatf("lzb_an_e%0d", k), {4'h0, an}, {4'h0, ea});
      chk($sformatf("lzb_seg_e%0d", k), seg, frame[d]);
    end
    // single-digit instance: an fixed low, seg one edge after capture
    chk("nd1_an", {7'h0, an1}, 8'h00);
    chk("nd1_seg_idle", seg1, 8'hC0);
    value1 = 4'h7; dp1 = 1'b1; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    chk("nd1_seg_capture", seg1, 8'hC0);
    tick();
    chk("nd1_seg_7dp", seg1, 8'h78);
    value1 = 4'hB; dp1 = 1'b0; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    chk("nd1_seg_hold", seg1, 8'h78);
    tick();
    chk("nd1_seg_b", seg1, 8'h83);
    chk("nd1_an_end", {7'h0, an1}, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
